// File: rtl/game_flow_ctrl_pkg.sv
// Shared game package: FSM state encoding, default timing parameters and
// the time-limit helper used by the flow controller and the timer/display block.
package game_flow_ctrl_pkg;

   localparam int unsigned TIME_W           = 32;
   localparam int unsigned DEBOUNCE_MS_DEF  = 20;
   localparam int unsigned TIME_LIMIT_DEF   = 0;
   localparam int unsigned SHOW_BEST_MS_DEF = 2000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_OVER  = 2'd3
   } game_state_e;

   // A zero limit means the game never times out.
   function automatic logic limit_reached(input logic [TIME_W-1:0] elapsed,
                                          input logic [TIME_W-1:0] limit);
      return (limit != '0) && (elapsed >= limit);
   endfunction

endpackage

// File: rtl/game_flow_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, debounce counter and press-edge detector.
// Ports: clk_1000/rst (async active-low), btn (raw, asynchronous),
//        press (one-cycle pulse on an accepted 0->1 of the debounced level).
module btn_debounce
   import game_flow_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEF
) (
   input  logic clk_1000,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int unsigned CNT_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

   logic             sync_q1;
   logic             sync_q2;
   logic             level;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] arm_cnt;
   logic             armed;

   // armed is only set once the input has been seen released for a full
   // debounce window, so a button held through reset cannot fire a press.
   always_ff @(posedge clk_1000 or negedge rst) begin
      if (!rst) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         level   <= 1'b0;
         cnt     <= '0;
         arm_cnt <= '0;
         armed   <= 1'b0;
         press   <= 1'b0;
      end else begin
         sync_q1 <= btn;
         sync_q2 <= sync_q1;
         press   <= 1'b0;

         if (sync_q2 != level) begin
            if (cnt == CNT_LAST) begin
               level <= sync_q2;
               cnt   <= '0;
               press <= sync_q2 & armed;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end

         if (!armed) begin
            if (sync_q2) begin
               arm_cnt <= '0;
            end else if (arm_cnt == CNT_LAST) begin
               armed <= 1'b1;
            end else begin
               arm_cnt <= arm_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow controller: conditions the start/pause buttons and sequences
// IDLE/RUN/PAUSE/OVER, tracking the best completed game time.
// Ports: clk_1000, rst (async active-low); btn_start, btn_pause (raw buttons);
//        hit (loss level), elapsed (game seconds); start/over (timer control),
//        paused, best_time, new_record, disp_sel (0 = elapsed, 1 = best_time).
module game_flow_ctrl
   import game_flow_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_MS  = DEBOUNCE_MS_DEF,
   parameter int unsigned TIME_LIMIT   = TIME_LIMIT_DEF,
   parameter int unsigned SHOW_BEST_MS = SHOW_BEST_MS_DEF
) (
   input  logic              clk_1000,
   input  logic              rst,
   input  logic              btn_start,
   input  logic              btn_pause,
   input  logic              hit,
   input  logic [TIME_W-1:0] elapsed,
   output logic              start,
   output logic              over,
   output logic              paused,
   output logic [TIME_W-1:0] best_time,
   output logic              new_record,
   output logic              disp_sel
);

   localparam int unsigned DISP_W = (SHOW_BEST_MS > 1) ? $clog2(SHOW_BEST_MS) : 1;
   localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(SHOW_BEST_MS - 1);

   game_state_e       state;
   logic              start_p;
   logic              pause_p;
   logic              time_up;
   logic [DISP_W-1:0] disp_cnt;

   btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_start_db (
      .clk_1000 (clk_1000),
      .rst      (rst),
      .btn      (btn_start),
      .press    (start_p)
   );

   btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_pause_db (
      .clk_1000 (clk_1000),
      .rst      (rst),
      .btn      (btn_pause),
      .press    (pause_p)
   );

   assign time_up = limit_reached(elapsed, TIME_W'(TIME_LIMIT));

   // State and all outputs move together on the transition edge.
   always_ff @(posedge clk_1000 or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         start      <= 1'b0;
         over       <= 1'b0;
         paused     <= 1'b0;
         best_time  <= '0;
         new_record <= 1'b0;
         disp_sel   <= 1'b0;
         disp_cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_p) begin
                  state <= ST_RUN;
                  start <= 1'b1;
               end
            end
            ST_RUN: begin
               // Loss and timeout outrank a simultaneous pause press.
               if (hit || time_up) begin
                  state    <= ST_OVER;
                  over     <= 1'b1;
                  disp_sel <= 1'b0;
                  disp_cnt <= '0;
                  if (elapsed > best_time) begin
                     best_time  <= elapsed;
                     new_record <= 1'b1;
                  end
               end else if (pause_p) begin
                  state  <= ST_PAUSE;
                  over   <= 1'b1;
                  paused <= 1'b1;
               end
            end
            ST_PAUSE: begin
               if (pause_p) begin
                  state  <= ST_RUN;
                  over   <= 1'b0;
                  paused <= 1'b0;
               end
            end
            ST_OVER: begin
               if (start_p) begin
                  state      <= ST_IDLE;
                  start      <= 1'b0;
                  over       <= 1'b0;
                  new_record <= 1'b0;
                  disp_sel   <= 1'b0;
                  disp_cnt   <= '0;
               end else if (disp_cnt == DISP_LAST) begin
                  disp_cnt <= '0;
                  disp_sel <= ~disp_sel;
               end else begin
                  disp_cnt <= disp_cnt + DISP_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: a game-level model pushes the expected
// output tuple on every predicted change; a monitor pops on each observed change.
module tb_game_flow_ctrl;

   localparam int unsigned DEB  = 20;
   localparam int unsigned TL   = 10;
   localparam int unsigned SHOW = 2000;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_OVER  = 3;

   typedef struct packed {
      logic        start;
      logic        over;
      logic        paused;
      logic        new_record;
      logic        disp_sel;
      logic [31:0] best;
   } obs_t;

   logic        clk_1000  = 1'b0;
   logic        rst       = 1'b0;
   logic        btn_start = 1'b0;
   logic        btn_pause = 1'b0;
   logic        hit       = 1'b0;
   logic [31:0] elapsed   = '0;
   logic        start;
   logic        over;
   logic        paused;
   logic [31:0] best_time;
   logic        new_record;
   logic        disp_sel;

   game_flow_ctrl #(
      .DEBOUNCE_MS  (DEB),
      .TIME_LIMIT   (TL),
      .SHOW_BEST_MS (SHOW)
   ) dut (
      .clk_1000   (clk_1000),
      .rst        (rst),
      .btn_start  (btn_start),
      .btn_pause  (btn_pause),
      .hit        (hit),
      .elapsed    (elapsed),
      .start      (start),
      .over       (over),
      .paused     (paused),
      .best_time  (best_time),
      .new_record (new_record),
      .disp_sel   (disp_sel)
   );

   always #5 clk_1000 = ~clk_1000;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   int          start_pulses = 0;

   obs_t exp_q[$];
   obs_t last_pushed = '0;
   obs_t seen = '0;

   int          m_mode = M_IDLE;
   logic [31:0] m_best = '0;
   logic [31:0] m_el   = '0;
   logic        m_nr   = 1'b0;
   logic        m_disp = 1'b0;

   always @(posedge clk_1000) cyc <= cyc + 1;

   always @(negedge clk_1000) if (dut.start_p === 1'b1) start_pulses++;

   function automatic string fmt(input obs_t o);
      return $sformatf("start=%0b over=%0b paused=%0b new_record=%0b disp_sel=%0b best=%0d",
                       o.start, o.over, o.paused, o.new_record, o.disp_sel, o.best);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, want);
      end
   endtask

   // ---------------- reference model (game rules) ----------------
   function automatic obs_t model_obs();
      obs_t o;
      o.start      = (m_mode != M_IDLE);
      o.over       = (m_mode == M_PAUSE) || (m_mode == M_OVER);
      o.paused     = (m_mode == M_PAUSE);
      o.new_record = m_nr;
      o.disp_sel   = m_disp;
      o.best       = m_best;
      return o;
   endfunction

   task automatic commit();
      obs_t o;
      o = model_obs();
      if (o !== last_pushed) begin
         exp_q.push_back(o);
         last_pushed = o;
      end
   endtask

   task automatic end_game();
      if (m_el > m_best) begin
         m_best = m_el;
         m_nr   = 1'b1;
      end else begin
         m_nr = 1'b0;
      end
      m_mode = M_OVER;
      m_disp = 1'b0;
      commit();
   endtask

   task automatic apply_limit();
      if (m_mode == M_RUN && m_el >= 32'(TL)) end_game();
   endtask

   task automatic model_start_press();
      if (m_mode == M_IDLE) begin
         m_mode = M_RUN;
         commit();
         apply_limit();
      end else if (m_mode == M_OVER) begin
         m_mode = M_IDLE;
         m_nr   = 1'b0;
         m_disp = 1'b0;
         commit();
      end
   endtask

   task automatic model_pause_press();
      if (m_mode == M_RUN) begin
         m_mode = M_PAUSE;
         commit();
      end else if (m_mode == M_PAUSE) begin
         m_mode = M_RUN;
         commit();
         apply_limit();
      end
   endtask

   task automatic model_hit(input logic [31:0] e);
      m_el = e;
      if (m_mode == M_RUN) end_game();
   endtask

   task automatic model_set_elapsed(input logic [31:0] e);
      m_el = e;
      apply_limit();
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_best = '0;
      m_nr   = 1'b0;
      m_disp = 1'b0;
      commit();
   endtask

   // ---------------- stimulus ----------------
   task automatic drive_btn(input int which, input logic v);
      if (which == 0) btn_start = v;
      else            btn_pause = v;
   endtask

   task automatic press(input int which, input bit bounce);
      @(negedge clk_1000);
      if (which == 0 && (m_mode == M_IDLE || m_mode == M_OVER)) begin
         elapsed = '0;
         m_el    = '0;
      end
      if (which == 0) model_start_press();
      else            model_pause_press();
      if (bounce) begin
         for (int i = 0; i < 5; i++) begin
            drive_btn(which, (i % 2) == 0);
            @(negedge clk_1000);
         end
         drive_btn(which, 1'b0);
         @(negedge clk_1000);
      end
      drive_btn(which, 1'b1);
      repeat (30) @(negedge clk_1000);
      drive_btn(which, 1'b0);
      repeat (30) @(negedge clk_1000);
   endtask

   task automatic do_hit(input logic [31:0] e);
      @(negedge clk_1000);
      elapsed = e;
      hit     = 1'b1;
      model_hit(e);
      @(negedge clk_1000);
      hit = 1'b0;
   endtask

   task automatic do_elapsed(input logic [31:0] e);
      @(negedge clk_1000);
      elapsed = e;
      model_set_elapsed(e);
      @(negedge clk_1000);
   endtask

   task automatic do_reset();
      @(negedge clk_1000);
      model_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk_1000);
      rst = 1'b1;
      repeat (DEB + 10) @(negedge clk_1000);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk_1000) begin
      obs_t cur;
      obs_t want;
      cur = {start, over, paused, new_record, disp_sel, best_time};
      if (cur !== seen) begin
         seen = cur;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: got %s, expected no change", fmt(cur));
         end else begin
            want = exp_q.pop_front();
            if (cur !== want) begin
               errors++;
               $display("FAIL output_change: got %s, expected %s", fmt(cur), fmt(want));
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- test sequence ----------------
   initial begin
      int lat;
      int p0;
      int unsigned t0;
      int unsigned t1;
      int unsigned t2;
      int over_ops;

      repeat (3) @(negedge clk_1000);
      rst = 1'b1;
      repeat (DEB + 10) @(negedge clk_1000);

      check("rst_start",      32'(start),      0);
      check("rst_over",       32'(over),       0);
      check("rst_paused",     32'(paused),     0);
      check("rst_best",       best_time,       0);
      check("rst_new_record", 32'(new_record), 0);
      check("rst_disp_sel",   32'(disp_sel),   0);

      // Bounced start press: one pulse, start rises DEB+3 edges after stable high.
      p0 = start_pulses;
      @(negedge clk_1000);
      elapsed = '0;
      m_el    = '0;
      model_start_press();
      for (int i = 0; i < 5; i++) begin
         btn_start = ((i % 2) == 0);
         @(negedge clk_1000);
      end
      btn_start = 1'b0;
      @(negedge clk_1000);
      btn_start = 1'b1;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk_1000);
         if (start === 1'b1 && lat < 0) lat = k;
      end
      btn_start = 1'b0;
      repeat (30) @(negedge clk_1000);
      check("start_latency",     32'(lat), DEB + 3);
      check("start_pulse_count", 32'(start_pulses - p0), 1);

      // Hit and pause pulse in the same cycle: loss wins.
      do_elapsed(7);
      @(negedge clk_1000);
      btn_pause = 1'b1;
      repeat (DEB + 2) @(negedge clk_1000);
      check("pause_pulse_aligned", 32'(dut.pause_p), 1);
      hit = 1'b1;
      model_hit(7);
      @(negedge clk_1000);
      hit = 1'b0;
      repeat (30) @(negedge clk_1000);
      btn_pause = 1'b0;
      repeat (30) @(negedge clk_1000);
      check("hit_prio_over",   32'(over),       1);
      check("hit_prio_paused", 32'(paused),     0);
      check("hit_prio_best",   best_time,       7);
      check("hit_prio_record", 32'(new_record), 1);
      press(0, 1'b0);
      check("restart_start",  32'(start),      0);
      check("restart_record", 32'(new_record), 0);

      // Pause / resume, hit ignored while paused.
      press(0, 1'b0);
      press(1, 1'b0);
      check("pause_paused", 32'(paused), 1);
      check("pause_over",   32'(over),   1);
      do_hit(3);
      repeat (5) @(negedge clk_1000);
      check("pause_hold_paused", 32'(paused), 1);
      check("pause_hold_start",  32'(start),  1);
      press(1, 1'b0);
      check("resume_over",   32'(over),   0);
      check("resume_paused", 32'(paused), 0);

      // Time limit with a higher best: no record; display alternation timing.
      do_elapsed(12);
      press(0, 1'b0);
      press(0, 1'b0);
      @(negedge clk_1000);
      elapsed = 32'd10;
      model_set_elapsed(10);
      m_disp = 1'b1;
      commit();
      m_disp = 1'b0;
      commit();
      t0 = 0;
      t1 = 0;
      t2 = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_1000);
         if (over === 1'b1 && t0 == 0) t0 = cyc;
      end
      for (int k = 0; k < SHOW + 50; k++) begin
         @(negedge clk_1000);
         if (disp_sel === 1'b1) begin
            t1 = cyc;
            break;
         end
      end
      for (int k = 0; k < SHOW + 50; k++) begin
         @(negedge clk_1000);
         if (disp_sel === 1'b0) begin
            t2 = cyc;
            break;
         end
      end
      check("limit_best",    best_time,       12);
      check("limit_record",  32'(new_record), 0);
      check("disp_toggle_1", t1 - t0, SHOW);
      check("disp_toggle_2", t2 - t0, 2 * SHOW);
      press(0, 1'b0);

      // Reset mid-game with start held through reset release.
      press(0, 1'b0);
      do_elapsed(9);
      @(negedge clk_1000);
      model_reset();
      rst       = 1'b0;
      elapsed   = 32'd50;
      m_el      = 32'd50;
      btn_start = 1'b1;
      repeat (3) @(negedge clk_1000);
      rst = 1'b1;
      p0  = start_pulses;
      repeat (80) @(negedge clk_1000);
      check("held_rst_start",  32'(start), 0);
      check("held_rst_best",   best_time,  0);
      check("held_rst_pulses", 32'(start_pulses - p0), 0);
      btn_start = 1'b0;
      repeat (30) @(negedge clk_1000);
      press(0, 1'b0);
      check("repress_start", 32'(start), 1);

      // Randomized games against the model.
      over_ops = 0;
      for (int n = 0; n < 120; n++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (m_mode == M_OVER) over_ops++;
         else                  over_ops = 0;
         if (over_ops >= 3) r = 0;
         if (r < 30)      press(0, 1'($urandom_range(0, 1)));
         else if (r < 55) press(1, 1'($urandom_range(0, 1)));
         else if (r < 75) do_hit(32'($urandom_range(0, 20)));
         else if (r < 96) do_elapsed(32'($urandom_range(0, 14)));
         else             do_reset();
         repeat ($urandom_range(1, 8)) @(negedge clk_1000);
      end

      for (int k = 0; k < 200; k++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk_1000);
      end
      check("queue_drained", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
